// File: rtl/mem_arbiter.sv
// mem_arbiter: three-port round-robin arbiter with lock, sharing one 1-cycle-latency memory
//   clk, rst_n               system clock, asynchronous active-low reset
//   reqN_i/weN_i/lockN_i     per-port request, write select, keep-ownership
//   addrN_i/wdataN_i         per-port address and write data
//   gntN_o                   combinational grant; the access happens this cycle
//   rvalidN_o                registered; rdata_o holds this port's read result
//   rdata_o                  shared read return, mirrors mem_rd_data_i
//   mem_*                    single-port memory interface
module mem_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_i,
  input  logic             req1_i,
  input  logic             req2_i,
  input  logic             we0_i,
  input  logic             we1_i,
  input  logic             we2_i,
  input  logic             lock0_i,
  input  logic             lock1_i,
  input  logic             lock2_i,
  input  logic [15:0]      addr0_i,
  input  logic [15:0]      addr1_i,
  input  logic [15:0]      addr2_i,
  input  logic [WIDTH-1:0] wdata0_i,
  input  logic [WIDTH-1:0] wdata1_i,
  input  logic [WIDTH-1:0] wdata2_i,
  output logic             gnt0_o,
  output logic             gnt1_o,
  output logic             gnt2_o,
  output logic             rvalid0_o,
  output logic             rvalid1_o,
  output logic             rvalid2_o,
  output logic [WIDTH-1:0] rdata_o,
  output logic [15:0]      mem_wr_addr_o,
  output logic [15:0]      mem_rd_addr_o,
  output logic             mem_wr_enable_o,
  output logic [WIDTH-1:0] mem_wr_data_o,
  input  logic [WIDTH-1:0] mem_rd_data_i
);
  // 4-entry vectors so a 2-bit port index can never select out of range
  logic [3:0]       req_v, we_v, lock_v;
  logic [1:0]       ptr_q, ptr_d, ptr_e, p1, p2, win, own_q, own_d;
  logic             own_vld_q, own_vld_d, hold, any;
  logic [2:0]       gnt, rvalid_q, rvalid_d;
  logic [15:0]      addr_w;
  logic [WIDTH-1:0] wdata_w;
  assign req_v  = {1'b0, req2_i, req1_i, req0_i};
  assign we_v   = {1'b0, we2_i, we1_i, we0_i};
  assign lock_v = {1'b0, lock2_i, lock1_i, lock0_i};
  always_comb begin
    ptr_e     = ptr_q == 2'd3 ? 2'd0 : ptr_q;
    p1        = ptr_e == 2'd2 ? 2'd0 : ptr_e + 2'd1;
    p2        = p1 == 2'd2 ? 2'd0 : p1 + 2'd1;
    // an owner that dropped its request loses priority in this same cycle
    hold      = own_vld_q && req_v[own_q];
    any       = rst_n && |req_v[2:0];
    win       = hold ? own_q : req_v[ptr_e] ? ptr_e : req_v[p1] ? p1 : p2;
    gnt       = {any && win == 2'd2, any && win == 2'd1, any && win == 2'd0};
    addr_w    = !any ? 16'd0 : win == 2'd2 ? addr2_i : win == 2'd1 ? addr1_i : addr0_i;
    wdata_w   = !any ? '0 : win == 2'd2 ? wdata2_i : win == 2'd1 ? wdata1_i : wdata0_i;
    ptr_d     = !any ? ptr_e : win == 2'd2 ? 2'd0 : win + 2'd1;
    own_vld_d = any ? lock_v[win] : hold;
    own_d     = any ? win : own_q;
    rvalid_d  = any && !we_v[win] ? gnt : 3'b000;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= 2'd0;
      own_q     <= 2'd0;
      own_vld_q <= 1'b0;
      rvalid_q  <= 3'b000;
    end else begin
      ptr_q     <= ptr_d;
      own_q     <= own_d;
      own_vld_q <= own_vld_d;
      rvalid_q  <= rvalid_d;
    end
  end
  assign gnt0_o          = gnt[0];
  assign gnt1_o          = gnt[1];
  assign gnt2_o          = gnt[2];
  assign rvalid0_o       = rvalid_q[0];
  assign rvalid1_o       = rvalid_q[1];
  assign rvalid2_o       = rvalid_q[2];
  assign rdata_o         = mem_rd_data_i;
  assign mem_wr_addr_o   = addr_w;
  assign mem_rd_addr_o   = addr_w;
  assign mem_wr_data_o   = wdata_w;
  assign mem_wr_enable_o = any && we_v[win];
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench with a per-cycle arbitration model for mem_arbiter
module tb_mem_arbiter;
  logic        clk = 0;
  logic        rst_n;
  logic [2:0]  req, we, lock, gnt, rv;
  logic [15:0] addr [3];
  logic [15:0] wdata [3];
  logic [15:0] rdata, wr_addr, rd_addr, wr_data, rd_data;
  logic        wen;
  logic [15:0] env_mem [256];
  logic [15:0] m_mem [256];
  int          m_ptr, m_own, m_pend, w, passed, total, rv0_cnt;
  logic [15:0] m_pdata;
  int          glog [$];

  mem_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_i(req[0]), .req1_i(req[1]), .req2_i(req[2]),
    .we0_i(we[0]), .we1_i(we[1]), .we2_i(we[2]),
    .lock0_i(lock[0]), .lock1_i(lock[1]), .lock2_i(lock[2]),
    .addr0_i(addr[0]), .addr1_i(addr[1]), .addr2_i(addr[2]),
    .wdata0_i(wdata[0]), .wdata1_i(wdata[1]), .wdata2_i(wdata[2]),
    .gnt0_o(gnt[0]), .gnt1_o(gnt[1]), .gnt2_o(gnt[2]),
    .rvalid0_o(rv[0]), .rvalid1_o(rv[1]), .rvalid2_o(rv[2]),
    .rdata_o(rdata), .mem_wr_addr_o(wr_addr), .mem_rd_addr_o(rd_addr),
    .mem_wr_enable_o(wen), .mem_wr_data_o(wr_data), .mem_rd_data_i(rd_data)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 256; i++) env_mem[i] <= (i == 16) ? 16'hBEEF : 16'(i * 3);
  always @(posedge clk) begin
    if (wen) env_mem[wr_addr[7:0]] <= wr_data;
    rd_data <= env_mem[rd_addr[7:0]];
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
  endtask

  function automatic logic [31:0] packlog();
    logic [31:0] v = 0;
    foreach (glog[i]) v = (v << 4) | 32'(glog[i]);
    return v;
  endfunction

  // model: owner with live request wins, else first requester from ptr; state advances per cycle
  always @(negedge clk) begin
    if (rv[0]) rv0_cnt++;
    if (!rst_n) begin
      chk("reset gnt", 32'(gnt), 0);
      chk("reset rvalid", 32'(rv), 0);
      chk("reset wen", 32'(wen), 0);
      m_ptr = 0; m_own = -1; m_pend = -1;
    end else begin
      w = -1;
      if (m_own >= 0 && req[m_own]) w = m_own;
      else for (int i = 0; i < 3; i++) if (w < 0 && req[(m_ptr + i) % 3]) w = (m_ptr + i) % 3;
      chk("gnt", 32'(gnt), w < 0 ? 0 : 32'(1) << w);
      chk("rvalid", 32'(rv), m_pend < 0 ? 0 : 32'(1) << m_pend);
      if (m_pend >= 0) chk("rdata", 32'(rdata), 32'(m_pdata));
      chk("wen", 32'(wen), w >= 0 ? 32'(we[w]) : 0);
      chk("wr_addr", 32'(wr_addr), w >= 0 ? 32'(addr[w]) : 0);
      chk("rd_addr", 32'(rd_addr), w >= 0 ? 32'(addr[w]) : 0);
      chk("wr_data", 32'(wr_data), w >= 0 ? 32'(wdata[w]) : 0);
      m_pend = -1;
      if (w >= 0) begin
        glog.push_back(w);
        if (we[w]) m_mem[addr[w][7:0]] = wdata[w];
        else begin m_pend = w; m_pdata = m_mem[addr[w][7:0]]; end
        m_ptr = (w + 1) % 3;
        m_own = lock[w] ? w : -1;
      end else if (m_own >= 0 && !req[m_own]) m_own = -1;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    passed = 0; total = 0; rv0_cnt = 0;
    for (int i = 0; i < 256; i++) m_mem[i] = (i == 16) ? 16'hBEEF : 16'(i * 3);
    rst_n = 0; req = 3'b111; we = 0; lock = 0;
    for (int i = 0; i < 3; i++) begin addr[i] = 16'h0010; wdata[i] = 16'h0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("gnt in reset", 32'(gnt), 0);
    chk("wen in reset", 32'(wen), 0);
    cyc();
    rst_n = 1; glog.delete();
    @(negedge clk);
    chk("first gnt after reset", 32'(gnt), 32'b001);
    @(posedge clk); #1;
    repeat (5) cyc();
    req = 0;
    @(negedge clk);
    chk("rr order", packlog(), 32'h012012);
    chk("rr count", 32'(glog.size()), 6);
    chk("last rr rvalid", 32'(rv), 32'b100);
    chk("last rr rdata", 32'(rdata), 32'hBEEF);
    cyc();
    req = 3'b010; we[1] = 1; addr[1] = 16'h00A0; wdata[1] = 16'h1234;
    @(negedge clk);
    chk("write wen", 32'(wen), 1);
    chk("write addr", 32'(wr_addr), 32'h00A0);
    chk("write data", 32'(wr_data), 32'h1234);
    cyc();
    req = 3'b100; we = 0; addr[2] = 16'h00A0;
    @(negedge clk);
    chk("no rvalid after write", 32'(rv), 0);
    chk("read gnt2", 32'(gnt), 32'b100);
    cyc();
    req = 0;
    @(negedge clk);
    chk("read back rvalid2", 32'(rv), 32'b100);
    chk("read back rdata", 32'(rdata), 32'h1234);
    cyc();
    req = 3'b010; addr[1] = 16'h0010; addr[2] = 16'h0010;
    cyc();
    req = 3'b111; lock[2] = 1; glog.delete();
    repeat (3) cyc();
    lock[2] = 0;
    cyc();
    req[2] = 0;
    cyc();
    cyc();
    req = 0;
    chk("lock burst order", packlog(), 32'h222201);
    chk("lock burst count", 32'(glog.size()), 6);
    cyc();
    req = 3'b010; lock[1] = 1; glog.delete();
    cyc();
    req = 3'b011;
    cyc();
    req = 3'b001; lock[1] = 0;
    @(negedge clk);
    chk("owner drop gnt0", 32'(gnt), 32'b001);
    cyc();
    req = 0;
    chk("owner drop order", packlog(), 32'h110);
    cyc();
    req = 3'b001; addr[0] = 16'h0010; rv0_cnt = 0;
    @(negedge clk);
    chk("mid-read gnt0", 32'(gnt), 32'b001);
    #1 rst_n = 0; req = 0;
    repeat (2) cyc();
    rst_n = 1; req = 3'b111;
    @(negedge clk);
    chk("ptr reset gnt0", 32'(gnt), 32'b001);
    cyc();
    req = 0;
    chk("discarded rvalid0", 32'(rv0_cnt), 0);
    cyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
